// File: rtl/lsu_io_responder.sv
// Data-side load/store responder: word-organised data RAM plus LED, HEX and switch I/O.
// Loads return sign/zero-extended data one cycle later; misaligned or illegal requests are flagged and suppressed.
module lsu_io_responder #(
  parameter int DMEM_AW = 11,
  parameter int SW_W    = 18,
  parameter int LEDR_W  = 18
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_vld,
  input  logic              i_we,
  input  logic [2:0]        i_funct3,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata,
  output logic              o_rvld,
  output logic              o_misalign,
  input  logic [SW_W-1:0]   i_io_sw,
  output logic [LEDR_W-1:0] o_io_ledr,
  output logic [6:0]        o_io_hex0,
  output logic [6:0]        o_io_hex1,
  output logic [6:0]        o_io_hex2,
  output logic [6:0]        o_io_hex3,
  output logic [6:0]        o_io_hex4,
  output logic [6:0]        o_io_hex5,
  output logic [6:0]        o_io_hex6,
  output logic [6:0]        o_io_hex7
);

  localparam int          RAM_WORDS = 1 << (DMEM_AW - 2);
  localparam logic [29:0] LEDR_WA   = 30'h0000_1C00;
  localparam logic [29:0] HEX_LO_WA = 30'h0000_1C08;
  localparam logic [29:0] HEX_HI_WA = 30'h0000_1C09;
  localparam logic [29:0] SW_WA     = 30'h0000_1E00;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [31:0]        ram_q [RAM_WORDS];
  logic [LEDR_W-1:0]  ledr_q, ledr_d;
  logic [6:0]         hex_q [8];
  logic [6:0]         hex_d [8];
  logic [SW_W-1:0]    sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               rvld_q, rvld_d;
  logic               misalign_q, misalign_d;

  logic               misalign_s, acc_s, wr_s, rd_s, is_ram_s;
  logic [3:0]         be_s;
  logic [31:0]        wdata_s, rd_word_s, ext_s;
  logic [29:0]        wa_s;
  logic [DMEM_AW-3:0] ram_idx_s;
  logic [7:0]         byte_s;
  logic [15:0]        half_s;

  assign wa_s      = i_addr[31:2];
  assign ram_idx_s = i_addr[DMEM_AW-1:2];
  assign is_ram_s  = (i_addr[31:DMEM_AW] == '0);
  assign acc_s     = i_req_vld & ~i_rst & ~misalign_s;
  assign wr_s      = acc_s & i_we;
  assign rd_s      = acc_s & ~i_we;

  // Width decode: lane enables, replicated store data and alignment check.
  always_comb begin
    misalign_s = 1'b0;
    be_s       = 4'b0000;
    wdata_s    = i_wdata;
    case (i_funct3)
      F3_B, F3_BU: begin
        be_s    = 4'b0001 << i_addr[1:0];
        wdata_s = {4{i_wdata[7:0]}};
      end
      F3_H, F3_HU: begin
        misalign_s = i_addr[0];
        be_s       = i_addr[1] ? 4'b1100 : 4'b0011;
        wdata_s    = {2{i_wdata[15:0]}};
      end
      F3_W: begin
        misalign_s = (i_addr[1:0] != 2'b00);
        be_s       = 4'b1111;
      end
      default: misalign_s = 1'b1;
    endcase
  end

  // Word read mux over RAM and I/O; unmapped words read as zero.
  always_comb begin
    if (is_ram_s) begin
      rd_word_s = ram_q[ram_idx_s];
    end else if (wa_s == LEDR_WA) begin
      rd_word_s = 32'(ledr_q);
    end else if (wa_s == HEX_LO_WA) begin
      rd_word_s = {1'b0, hex_q[3], 1'b0, hex_q[2], 1'b0, hex_q[1], 1'b0, hex_q[0]};
    end else if (wa_s == HEX_HI_WA) begin
      rd_word_s = {1'b0, hex_q[7], 1'b0, hex_q[6], 1'b0, hex_q[5], 1'b0, hex_q[4]};
    end else if (wa_s == SW_WA) begin
      rd_word_s = 32'(sw_sync_q);
    end else begin
      rd_word_s = 32'h0000_0000;
    end
  end

  // Lane selection and sign/zero extension of the load result.
  always_comb begin
    case (i_addr[1:0])
      2'b00:   byte_s = rd_word_s[7:0];
      2'b01:   byte_s = rd_word_s[15:8];
      2'b10:   byte_s = rd_word_s[23:16];
      default: byte_s = rd_word_s[31:24];
    endcase
    half_s = i_addr[1] ? rd_word_s[31:16] : rd_word_s[15:0];
    case (i_funct3)
      F3_B:    ext_s = {{24{byte_s[7]}}, byte_s};
      F3_BU:   ext_s = {24'h00_0000, byte_s};
      F3_H:    ext_s = {{16{half_s[15]}}, half_s};
      F3_HU:   ext_s = {16'h0000, half_s};
      default: ext_s = rd_word_s;
    endcase
  end

  // Next-state for I/O registers, synchronizer and response registers.
  always_comb begin
    for (int k = 0; k < LEDR_W; k++) begin
      ledr_d[k] = (wr_s && (wa_s == LEDR_WA) && be_s[k/8]) ? wdata_s[k] : ledr_q[k];
    end
    for (int i = 0; i < 8; i++) begin
      hex_d[i] = (wr_s && (wa_s == HEX_LO_WA + 30'(i/4)) && be_s[i%4]) ?
                 wdata_s[(i%4)*8 +: 7] : hex_q[i];
    end
    sw_meta_d  = i_io_sw;
    sw_sync_d  = sw_meta_q;
    rvld_d     = rd_s;
    rdata_d    = rd_s ? ext_s : rdata_q;
    misalign_d = i_req_vld & misalign_s & ~i_rst;
  end

  // Byte-enabled RAM write; contents deliberately survive reset.
  always_ff @(posedge i_clk) begin
    if (wr_s && is_ram_s) begin
      for (int b = 0; b < 4; b++) begin
        if (be_s[b]) begin
          ram_q[ram_idx_s][b*8 +: 8] <= wdata_s[b*8 +: 8];
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ledr_q     <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      rdata_q    <= 32'h0000_0000;
      rvld_q     <= 1'b0;
      misalign_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        hex_q[i] <= 7'h7F;
      end
    end else begin
      ledr_q     <= ledr_d;
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
      rdata_q    <= rdata_d;
      rvld_q     <= rvld_d;
      misalign_q <= misalign_d;
      for (int i = 0; i < 8; i++) begin
        hex_q[i] <= hex_d[i];
      end
    end
  end

  assign o_rdata    = rdata_q;
  assign o_rvld     = rvld_q;
  assign o_misalign = misalign_q;
  assign o_io_ledr  = ledr_q;
  assign o_io_hex0  = hex_q[0];
  assign o_io_hex1  = hex_q[1];
  assign o_io_hex2  = hex_q[2];
  assign o_io_hex3  = hex_q[3];
  assign o_io_hex4  = hex_q[4];
  assign o_io_hex5  = hex_q[5];
  assign o_io_hex6  = hex_q[6];
  assign o_io_hex7  = hex_q[7];

endmodule
